// File: rtl/mmu_port_arbiter.sv
// Shares the MMU core-side AXI-lite port between instruction fetch and data
// load/store. Optional round-robin between the two sides: define ARB_RR_EN.
module mmu_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_araddr,
    input  logic                i_arvalid,
    output logic                i_arready,
    output logic [DATA_W-1:0]   i_rdata,
    output logic [1:0]          i_rresp,
    output logic                i_rvalid,
    input  logic                i_rready,
    output logic                i_exc,
    output logic [2:0]          i_exc_vec,
    input  logic [ADDR_W-1:0]   d_araddr,
    input  logic                d_arvalid,
    output logic                d_arready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [1:0]          d_rresp,
    output logic                d_rvalid,
    input  logic                d_rready,
    input  logic [ADDR_W-1:0]   d_awaddr,
    input  logic                d_awvalid,
    output logic                d_awready,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic                d_wvalid,
    output logic                d_wready,
    output logic [1:0]          d_bresp,
    output logic                d_bvalid,
    input  logic                d_bready,
    output logic                d_exc,
    output logic [2:0]          d_exc_vec,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic                is_instr,
    input  logic                m_exc,
    input  logic [2:0]          m_exc_vec
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_ADDR  = 4'd1,
        RD_DATA  = 4'd2,
        RD_RESP  = 4'd3,
        WR_ADDR  = 4'd4,
        WR_DATA  = 4'd5,
        WR_MDATA = 4'd6,
        WR_RESP  = 4'd7,
        WR_BRESP = 4'd8
    } state_t;

    state_t              r_state,     w_state;
    logic                r_i_arready, w_i_arready;
    logic [DATA_W-1:0]   r_i_rdata,   w_i_rdata;
    logic [1:0]          r_i_rresp,   w_i_rresp;
    logic                r_i_rvalid,  w_i_rvalid;
    logic                r_i_exc,     w_i_exc;
    logic [2:0]          r_i_exc_vec, w_i_exc_vec;
    logic                r_d_arready, w_d_arready;
    logic [DATA_W-1:0]   r_d_rdata,   w_d_rdata;
    logic [1:0]          r_d_rresp,   w_d_rresp;
    logic                r_d_rvalid,  w_d_rvalid;
    logic                r_d_awready, w_d_awready;
    logic                r_d_wready,  w_d_wready;
    logic [1:0]          r_d_bresp,   w_d_bresp;
    logic                r_d_bvalid,  w_d_bvalid;
    logic                r_d_exc,     w_d_exc;
    logic [2:0]          r_d_exc_vec, w_d_exc_vec;
    logic [ADDR_W-1:0]   r_m_araddr,  w_m_araddr;
    logic                r_m_arvalid, w_m_arvalid;
    logic                r_m_rready,  w_m_rready;
    logic [ADDR_W-1:0]   r_m_awaddr,  w_m_awaddr;
    logic                r_m_awvalid, w_m_awvalid;
    logic [DATA_W-1:0]   r_m_wdata,   w_m_wdata;
    logic [STRB_W-1:0]   r_m_wstrb,   w_m_wstrb;
    logic                r_m_wvalid,  w_m_wvalid;
    logic                r_m_bready,  w_m_bready;
    logic                r_is_instr,  w_is_instr;

    logic w_pick_i;
    logic w_gnt_dar;
    logic w_gnt_daw;
    logic w_gnt_iar;
    logic w_own_rready;

`ifdef ARB_RR_EN
    // r_last_instr: 1 when the most recent grant went to fetch (reset = data side).
    logic r_last_instr;
    assign w_pick_i = i_arvalid & (~(d_arvalid | d_awvalid) | ~r_last_instr);

    // Remember which side was served last so a contended IDLE flips the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_instr <= 1'b0;
        end else if (r_state == IDLE && (w_gnt_dar || w_gnt_daw || w_gnt_iar)) begin
            r_last_instr <= w_gnt_iar;
        end else begin
            r_last_instr <= r_last_instr;
        end
    end
`else
    assign w_pick_i = i_arvalid & ~d_arvalid & ~d_awvalid;
`endif

    assign w_gnt_iar    = w_pick_i;
    assign w_gnt_dar    = d_arvalid & ~w_pick_i;
    assign w_gnt_daw    = d_awvalid & ~d_arvalid & ~w_pick_i;
    assign w_own_rready = r_is_instr ? i_rready : d_rready;

    // Next-state and next-output computation; every register holds unless changed.
    always_comb begin
        w_state     = r_state;
        w_i_arready = 1'b0;
        w_d_arready = 1'b0;
        w_d_awready = 1'b0;
        w_i_rdata   = r_i_rdata;
        w_i_rresp   = r_i_rresp;
        w_i_rvalid  = r_i_rvalid;
        w_i_exc     = r_i_exc;
        w_i_exc_vec = r_i_exc_vec;
        w_d_rdata   = r_d_rdata;
        w_d_rresp   = r_d_rresp;
        w_d_rvalid  = r_d_rvalid;
        w_d_wready  = r_d_wready;
        w_d_bresp   = r_d_bresp;
        w_d_bvalid  = r_d_bvalid;
        w_d_exc     = r_d_exc;
        w_d_exc_vec = r_d_exc_vec;
        w_m_araddr  = r_m_araddr;
        w_m_arvalid = r_m_arvalid;
        w_m_rready  = r_m_rready;
        w_m_awaddr  = r_m_awaddr;
        w_m_awvalid = r_m_awvalid;
        w_m_wdata   = r_m_wdata;
        w_m_wstrb   = r_m_wstrb;
        w_m_wvalid  = r_m_wvalid;
        w_m_bready  = r_m_bready;
        w_is_instr  = r_is_instr;

        case (r_state)
            IDLE: begin
                if (w_gnt_dar) begin
                    w_d_arready = 1'b1;
                    w_m_araddr  = d_araddr;
                    w_m_arvalid = 1'b1;
                    w_is_instr  = 1'b0;
                    w_state     = RD_ADDR;
                end else if (w_gnt_daw) begin
                    w_d_awready = 1'b1;
                    w_m_awaddr  = d_awaddr;
                    w_m_awvalid = 1'b1;
                    w_is_instr  = 1'b0;
                    w_state     = WR_ADDR;
                end else if (w_gnt_iar) begin
                    w_i_arready = 1'b1;
                    w_m_araddr  = i_araddr;
                    w_m_arvalid = 1'b1;
                    w_is_instr  = 1'b1;
                    w_state     = RD_ADDR;
                end else begin
                    w_state = IDLE;
                end
            end
            RD_ADDR: begin
                if (m_arready) begin
                    w_m_arvalid = 1'b0;
                    w_m_rready  = 1'b1;
                    w_state     = RD_DATA;
                end else begin
                    w_state = RD_ADDR;
                end
            end
            // Fault info is captured only on the response handshake, into the owner's side.
            RD_DATA: begin
                if (m_rvalid) begin
                    w_m_rready = 1'b0;
                    w_state    = RD_RESP;
                    if (r_is_instr) begin
                        w_i_rdata   = m_rdata;
                        w_i_rresp   = m_rresp;
                        w_i_exc     = m_exc;
                        w_i_exc_vec = m_exc_vec;
                        w_i_rvalid  = 1'b1;
                    end else begin
                        w_d_rdata   = m_rdata;
                        w_d_rresp   = m_rresp;
                        w_d_exc     = m_exc;
                        w_d_exc_vec = m_exc_vec;
                        w_d_rvalid  = 1'b1;
                    end
                end else begin
                    w_state = RD_DATA;
                end
            end
            RD_RESP: begin
                if (w_own_rready) begin
                    w_i_rvalid  = 1'b0;
                    w_i_exc     = 1'b0;
                    w_i_exc_vec = 3'b000;
                    w_d_rvalid  = 1'b0;
                    w_d_exc     = 1'b0;
                    w_d_exc_vec = 3'b000;
                    w_is_instr  = 1'b0;
                    w_state     = IDLE;
                end else begin
                    w_state = RD_RESP;
                end
            end
            WR_ADDR: begin
                if (m_awready) begin
                    w_m_awvalid = 1'b0;
                    w_d_wready  = 1'b1;
                    w_state     = WR_DATA;
                end else begin
                    w_state = WR_ADDR;
                end
            end
            WR_DATA: begin
                if (d_wvalid) begin
                    w_d_wready = 1'b0;
                    w_m_wdata  = d_wdata;
                    w_m_wstrb  = d_wstrb;
                    w_m_wvalid = 1'b1;
                    w_state    = WR_MDATA;
                end else begin
                    w_state = WR_DATA;
                end
            end
            WR_MDATA: begin
                if (m_wready) begin
                    w_m_wvalid = 1'b0;
                    w_m_bready = 1'b1;
                    w_state    = WR_RESP;
                end else begin
                    w_state = WR_MDATA;
                end
            end
            WR_RESP: begin
                if (m_bvalid) begin
                    w_m_bready  = 1'b0;
                    w_d_bresp   = m_bresp;
                    w_d_exc     = m_exc;
                    w_d_exc_vec = m_exc_vec;
                    w_d_bvalid  = 1'b1;
                    w_state     = WR_BRESP;
                end else begin
                    w_state = WR_RESP;
                end
            end
            WR_BRESP: begin
                if (d_bready) begin
                    w_d_bvalid  = 1'b0;
                    w_d_exc     = 1'b0;
                    w_d_exc_vec = 3'b000;
                    w_state     = IDLE;
                end else begin
                    w_state = WR_BRESP;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears every output at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_i_arready <= 1'b0;
            r_i_rdata   <= {DATA_W{1'b0}};
            r_i_rresp   <= 2'b00;
            r_i_rvalid  <= 1'b0;
            r_i_exc     <= 1'b0;
            r_i_exc_vec <= 3'b000;
            r_d_arready <= 1'b0;
            r_d_rdata   <= {DATA_W{1'b0}};
            r_d_rresp   <= 2'b00;
            r_d_rvalid  <= 1'b0;
            r_d_awready <= 1'b0;
            r_d_wready  <= 1'b0;
            r_d_bresp   <= 2'b00;
            r_d_bvalid  <= 1'b0;
            r_d_exc     <= 1'b0;
            r_d_exc_vec <= 3'b000;
            r_m_araddr  <= {ADDR_W{1'b0}};
            r_m_arvalid <= 1'b0;
            r_m_rready  <= 1'b0;
            r_m_awaddr  <= {ADDR_W{1'b0}};
            r_m_awvalid <= 1'b0;
            r_m_wdata   <= {DATA_W{1'b0}};
            r_m_wstrb   <= {STRB_W{1'b0}};
            r_m_wvalid  <= 1'b0;
            r_m_bready  <= 1'b0;
            r_is_instr  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_i_arready <= w_i_arready;
            r_i_rdata   <= w_i_rdata;
            r_i_rresp   <= w_i_rresp;
            r_i_rvalid  <= w_i_rvalid;
            r_i_exc     <= w_i_exc;
            r_i_exc_vec <= w_i_exc_vec;
            r_d_arready <= w_d_arready;
            r_d_rdata   <= w_d_rdata;
            r_d_rresp   <= w_d_rresp;
            r_d_rvalid  <= w_d_rvalid;
            r_d_awready <= w_d_awready;
            r_d_wready  <= w_d_wready;
            r_d_bresp   <= w_d_bresp;
            r_d_bvalid  <= w_d_bvalid;
            r_d_exc     <= w_d_exc;
            r_d_exc_vec <= w_d_exc_vec;
            r_m_araddr  <= w_m_araddr;
            r_m_arvalid <= w_m_arvalid;
            r_m_rready  <= w_m_rready;
            r_m_awaddr  <= w_m_awaddr;
            r_m_awvalid <= w_m_awvalid;
            r_m_wdata   <= w_m_wdata;
            r_m_wstrb   <= w_m_wstrb;
            r_m_wvalid  <= w_m_wvalid;
            r_m_bready  <= w_m_bready;
            r_is_instr  <= w_is_instr;
        end
    end

    assign i_arready = r_i_arready;
    assign i_rdata   = r_i_rdata;
    assign i_rresp   = r_i_rresp;
    assign i_rvalid  = r_i_rvalid;
    assign i_exc     = r_i_exc;
    assign i_exc_vec = r_i_exc_vec;
    assign d_arready = r_d_arready;
    assign d_rdata   = r_d_rdata;
    assign d_rresp   = r_d_rresp;
    assign d_rvalid  = r_d_rvalid;
    assign d_awready = r_d_awready;
    assign d_wready  = r_d_wready;
    assign d_bresp   = r_d_bresp;
    assign d_bvalid  = r_d_bvalid;
    assign d_exc     = r_d_exc;
    assign d_exc_vec = r_d_exc_vec;
    assign m_araddr  = r_m_araddr;
    assign m_arvalid = r_m_arvalid;
    assign m_rready  = r_m_rready;
    assign m_awaddr  = r_m_awaddr;
    assign m_awvalid = r_m_awvalid;
    assign m_wdata   = r_m_wdata;
    assign m_wstrb   = r_m_wstrb;
    assign m_wvalid  = r_m_wvalid;
    assign m_bready  = r_m_bready;
    assign is_instr  = r_is_instr;

endmodule

// File: doc/mmu_port_arbiter.md
Name: mmu_port_arbiter

Overview:
- Shares the MMU's single core-side AXI-lite port between two requesters: instruction fetch (read-only) and data load/store (read and write).
- Serialises transactions, one outstanding at a time.
- Drives the MMU's `is_instr` and holds it stable for the whole transaction.
- Captures `throw_exception`/`exception_vec` with each MMU response and routes them to the requester that issued the transaction.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_araddr in ADDR_W; i_arvalid in 1; i_arready out 1 — fetch read address
- i_rdata out DATA_W; i_rresp out 2; i_rvalid out 1; i_rready in 1 — fetch read data
- i_exc out 1; i_exc_vec out 3 — fetch fault info, valid with i_rvalid
- d_araddr in ADDR_W; d_arvalid in 1; d_arready out 1 — data read address
- d_rdata out DATA_W; d_rresp out 2; d_rvalid out 1; d_rready in 1 — data read data
- d_awaddr in ADDR_W; d_awvalid in 1; d_awready out 1 — data write address
- d_wdata in DATA_W; d_wstrb in 4; d_wvalid in 1; d_wready out 1 — data write data
- d_bresp out 2; d_bvalid out 1; d_bready in 1 — data write response
- d_exc out 1; d_exc_vec out 3 — data fault info, valid with d_rvalid/d_bvalid
- m_araddr, m_arvalid out; m_arready in — to MMU c_axi_ar*
- m_rdata, m_rresp in; m_rvalid in; m_rready out — to MMU c_axi_r*
- m_awaddr, m_awvalid out; m_awready in — to MMU c_axi_aw*
- m_wdata, m_wstrb, m_wvalid out; m_wready in — to MMU c_axi_w*
- m_bresp, m_bvalid in; m_bready out — to MMU c_axi_b*
- is_instr out 1 — to MMU
- m_exc in 1; m_exc_vec in 3 — from MMU throw_exception/exception_vec

Behaviour:
- Fixed: single clock `clk`; `rst` is synchronous and active-high.
- All outputs are registered. All outputs reset to 0; FSM resets to IDLE.
- States: IDLE, RD_ADDR, RD_DATA, RD_RESP, WR_ADDR, WR_DATA, WR_MDATA, WR_RESP, WR_BRESP.
- IDLE, arbitration:
  - Candidates: d_arvalid, d_awvalid, i_arvalid.
  - Fixed priority is d_ar > d_aw > i_ar.
  - The winner's ready (d_arready, d_awready or i_arready) pulses high for exactly 1 cycle, and its address is latched.
  - is_instr <= 1 for an i_ar grant, 0 otherwise.
  - Next state: RD_ADDR for a read, WR_ADDR for a write.
  - An xx_ready is never asserted unless the matching valid was high in that cycle.
- RD_ADDR:
  - m_arvalid=1 with the latched address, held until m_arready is sampled high.
  - On that cycle: m_arvalid<=0, m_rready<=1, go to RD_DATA.
- RD_DATA:
  - On m_rvalid: m_rready<=0.
  - Latch m_rdata, m_rresp, m_exc, m_exc_vec.
  - Raise i_rvalid or d_rvalid per the owner. Go to RD_RESP.
- RD_RESP:
  - Hold the owner's rvalid, data, resp, exc and exc_vec stable until its rready.
  - Then clear rvalid, exc and exc_vec; is_instr<=0; go to IDLE.
- WR_ADDR:
  - m_awvalid=1 until m_awready is sampled high, then go to WR_DATA.
- WR_DATA:
  - d_wready=1 until d_wvalid; latch wdata/wstrb, then go to WR_MDATA.
- WR_MDATA:
  - m_wvalid=1 with the latched data until m_wready.
  - Then m_bready<=1; go to WR_RESP.
- WR_RESP:
  - On m_bvalid: m_bready<=0.
  - Latch m_bresp, m_exc, m_exc_vec; d_bvalid<=1; go to WR_BRESP.
- WR_BRESP:
  - Hold until d_bready, then clear and go to IDLE.
- Fault capture:
  - m_exc/m_exc_vec are sampled only in the cycle the MMU response handshakes.
  - Values at other times are ignored.
  - Fault info is never presented on the non-owning requester.
- Simultaneous events:
  - A request arriving during a busy transaction waits; its valid must stay high.
  - A request arriving in the same cycle as the return to IDLE is arbitrated on the following cycle.
  - Minimum gap between grants is 1 IDLE cycle.
- Responses are passed through unchanged; the arbiter never generates errors itself.
- Reset mid-transaction: return to IDLE and drop all valids/readies immediately. The MMU must be reset in the same cycle.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined:
  - 1-bit last_owner register (reset = data).
  - When both the instruction and data sides request in IDLE, the side not served last wins.
  - Within the data side, read still beats write.
- Undefined: fixed priority d_ar > d_aw > i_ar; fetch can starve under continuous data traffic.

Test Plan:
- Fetch read:
  - Stimulus: i_araddr=0x00001000; MMU returns rdata=0xDEADBEEF, resp=0, exc=0.
  - Response: i_rvalid with i_rdata=0xDEADBEEF; is_instr=1 from grant to i_rready; d_rvalid stays 0.
- Data write:
  - Stimulus: d_awaddr=0x80000004, d_wdata=0x41000000, d_wstrb=0xF; MMU returns bresp=0.
  - Response: m_awaddr/m_wdata match exactly; d_bresp=0; is_instr=0 throughout.
- Same-cycle d_arvalid and i_arvalid, macro off:
  - Response: data read is granted first; fetch is granted after d_rready.
  - With ARB_RR_EN and last_owner=data: fetch is granted first.
- Fetch page fault:
  - Stimulus: MMU returns rvalid with m_exc=1, m_exc_vec=3'b001.
  - Response: i_exc=1, i_exc_vec=3'b001 held until i_rready; d_exc stays 0.
- Backpressure:
  - Stimulus: i_rready low for 5 cycles while d_arvalid is high.
  - Response: i_rvalid and data stay stable; d_arready stays 0 until the fetch completes.
- Reset mid-transaction:
  - Stimulus: assert rst during WR_MDATA.
  - Response: next cycle all outputs are 0 and the FSM is in IDLE; a new d_ar is granted after rst is deasserted.
